// File: rtl/regfile_ctrl.sv
// regfile_ctrl: multi-cycle sequencer driving a 4-entry register file, ALU and bus mux.
// Optional feature: define REGFILE_CTRL_ICOUNT_EN to count retired instructions on ICOUNT.
module regfile_ctrl (
  input  logic       CLKb,
  input  logic       RSTb,
  input  logic [9:0] INSTR,
  input  logic       IVALID,
  output logic       IREADY,
  output logic       ENW,
  output logic [1:0] WRA,
  output logic       ENR0,
  output logic [1:0] RDA0,
  output logic       ENR1,
  output logic [1:0] RDA1,
  output logic [2:0] ALU_OP,
  output logic       G_LD,
  output logic [1:0] BUS_SEL,
  output logic       DONE,
  output logic       ILLEGAL,
  output logic [9:0] ICOUNT
);

  typedef enum logic [1:0] {IDLE, T1, T2, FIN} state_t;

  typedef struct packed {
    logic       enw;
    logic [1:0] wra;
    logic       enr0;
    logic [1:0] rda0;
    logic       enr1;
    logic [1:0] rda1;
    logic [2:0] alu_op;
    logic       g_ld;
    logic [1:0] bus_sel;
  } ctrl_t;

  state_t     state_reg;
  logic [7:0] ir_reg;
  logic       ready_reg;
  logic       done_reg;
  logic       illegal_reg;
  ctrl_t      ctrl_reg;

  // INSTR[1:0] carries no meaning for this controller.
  logic unused_instr_bits;
  assign unused_instr_bits = ^INSTR[1:0];

  // Instruction fields below are {opcode[3:0], rx[1:0], ry[1:0]}.
  function automatic logic is_alu(input logic [3:0] op);
    return (op >= 4'd2) && (op <= 4'd6);
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    return 3'(op - 4'd2);
  endfunction

  function automatic ctrl_t t1_ctrl(input logic [7:0] ins);
    ctrl_t c;
    c = '0;
    if (ins[7:4] == 4'd0) begin
      c.bus_sel = 2'b01;
      c.enw     = 1'b1;
      c.wra     = ins[3:2];
    end else if (ins[7:4] == 4'd1) begin
      c.enr0    = 1'b1;
      c.rda0    = ins[1:0];
      c.bus_sel = 2'b10;
      c.enw     = 1'b1;
      c.wra     = ins[3:2];
    end else if (is_alu(ins[7:4])) begin
      c.enr0    = 1'b1;
      c.rda0    = ins[3:2];
      c.enr1    = 1'b1;
      c.rda1    = ins[1:0];
      c.alu_op  = alu_code(ins[7:4]);
      c.g_ld    = 1'b1;
    end
    return c;
  endfunction

  function automatic ctrl_t t2_ctrl(input logic [7:0] ins);
    ctrl_t c;
    c = '0;
    c.bus_sel = 2'b11;
    c.enw     = 1'b1;
    c.wra     = ins[3:2];
    c.alu_op  = alu_code(ins[7:4]);
    return c;
  endfunction

  // Outputs are loaded together with the state they belong to, so every output is a flop.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state_reg   <= IDLE;
      ir_reg      <= '0;
      ready_reg   <= 1'b0;
      ctrl_reg    <= '0;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      ctrl_reg    <= '0;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (IVALID && ready_reg) begin
            ir_reg    <= INSTR[9:2];
            ready_reg <= 1'b0;
            state_reg <= T1;
            ctrl_reg  <= t1_ctrl(INSTR[9:2]);
          end else begin
            ready_reg <= 1'b1;
          end
        end
        T1: begin
          if (is_alu(ir_reg[7:4])) begin
            state_reg <= T2;
            ctrl_reg  <= t2_ctrl(ir_reg);
          end else begin
            state_reg   <= FIN;
            done_reg    <= 1'b1;
            illegal_reg <= (ir_reg[7:4] >= 4'd7);
          end
        end
        T2: begin
          state_reg <= FIN;
          done_reg  <= 1'b1;
        end
        FIN: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign IREADY  = ready_reg;
  assign ENW     = ctrl_reg.enw;
  assign WRA     = ctrl_reg.wra;
  assign ENR0    = ctrl_reg.enr0;
  assign RDA0    = ctrl_reg.rda0;
  assign ENR1    = ctrl_reg.enr1;
  assign RDA1    = ctrl_reg.rda1;
  assign ALU_OP  = ctrl_reg.alu_op;
  assign G_LD    = ctrl_reg.g_ld;
  assign BUS_SEL = ctrl_reg.bus_sel;
  assign DONE    = done_reg;
  assign ILLEGAL = illegal_reg;

`ifdef REGFILE_CTRL_ICOUNT_EN
  logic [9:0] icount_reg;

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      icount_reg <= '0;
    end else if (done_reg) begin
      icount_reg <= icount_reg + 10'd1;
    end
  end

  assign ICOUNT = icount_reg;
`else
  assign ICOUNT = '0;
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: per-instruction expected-cycle queue plus directed literal checks.
module tb_regfile_ctrl;

  logic       CLKb = 1'b0;
  logic       RSTb = 1'b0;
  logic       IVALID = 1'b0;
  logic [9:0] INSTR = '0;
  logic       IREADY, ENW, ENR0, ENR1, G_LD, DONE, ILLEGAL;
  logic [1:0] WRA, RDA0, RDA1, BUS_SEL;
  logic [2:0] ALU_OP;
  logic [9:0] ICOUNT;

  typedef struct packed {
    logic       ready;
    logic       enw;
    logic [1:0] wra;
    logic       enr0;
    logic [1:0] rda0;
    logic       enr1;
    logic [1:0] rda1;
    logic [2:0] alu_op;
    logic       g_ld;
    logic [1:0] bus_sel;
    logic       done;
    logic       illegal;
    logic [9:0] icount;
  } obs_t;

`ifdef REGFILE_CTRL_ICOUNT_EN
  localparam int HALF_CNT = 512;
`else
  localparam int HALF_CNT = 0;
`endif

  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  bit   cmp_en = 1'b0;
  obs_t exp_o = '0;
  obs_t plan[$];
  obs_t t1, t2, fin;

  always #5 CLKb = ~CLKb;

  regfile_ctrl dut (
    .CLKb(CLKb), .RSTb(RSTb), .INSTR(INSTR), .IVALID(IVALID), .IREADY(IREADY),
    .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
    .ALU_OP(ALU_OP), .G_LD(G_LD), .BUS_SEL(BUS_SEL), .DONE(DONE), .ILLEGAL(ILLEGAL),
    .ICOUNT(ICOUNT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.ready = IREADY;  o.enw = ENW;       o.wra = WRA;
    o.enr0 = ENR0;     o.rda0 = RDA0;     o.enr1 = ENR1;  o.rda1 = RDA1;
    o.alu_op = ALU_OP; o.g_ld = G_LD;     o.bus_sel = BUS_SEL;
    o.done = DONE;     o.illegal = ILLEGAL; o.icount = ICOUNT;
    return o;
  endfunction

  // Expected output cycles of one instruction, straight from the opcode table.
  task automatic plan_instr(input logic [9:0] ins);
    obs_t a, b, f;
    int op;
    op = int'(ins[9:6]);
    a = '0; b = '0; f = '0;
    f.done = 1'b1;
    if (op == 0) begin
      a.enw = 1'b1; a.wra = ins[5:4]; a.bus_sel = 2'd1;
      plan.push_back(a);
    end else if (op == 1) begin
      a.enw = 1'b1; a.wra = ins[5:4]; a.enr0 = 1'b1; a.rda0 = ins[3:2]; a.bus_sel = 2'd2;
      plan.push_back(a);
    end else if (op <= 6) begin
      a.enr0 = 1'b1; a.rda0 = ins[5:4]; a.enr1 = 1'b1; a.rda1 = ins[3:2];
      a.alu_op = 3'(op - 2); a.g_ld = 1'b1;
      b.bus_sel = 2'd3; b.enw = 1'b1; b.wra = ins[5:4]; b.alu_op = a.alu_op;
      plan.push_back(a);
      plan.push_back(b);
    end else begin
      f.illegal = 1'b1;
      plan.push_back(a);
    end
    plan.push_back(f);
  endtask

  always @(posedge CLKb or negedge RSTb) begin : model
    obs_t nxt;
    if (!RSTb) begin
      plan.delete();
      model_cnt = 0;
      exp_o <= '0;
    end else begin
`ifdef REGFILE_CTRL_ICOUNT_EN
      if (exp_o.done) model_cnt = (model_cnt + 1) % 1024;
`endif
      if (plan.size() == 0 && exp_o.ready && IVALID) plan_instr(INSTR);
      if (plan.size() != 0) begin
        nxt = plan.pop_front();
      end else begin
        nxt = '0;
        nxt.ready = 1'b1;
      end
      nxt.icount = 10'(model_cnt);
      exp_o <= nxt;
    end
  end

  always @(negedge CLKb) begin : compare
    obs_t a;
    if (cmp_en) begin
      a = sample();
      chk("cyc_IREADY", a.ready, exp_o.ready);
      chk("cyc_ENW", a.enw, exp_o.enw);
      chk("cyc_WRA", a.wra, exp_o.wra);
      chk("cyc_ENR0", a.enr0, exp_o.enr0);
      chk("cyc_RDA0", a.rda0, exp_o.rda0);
      chk("cyc_ENR1", a.enr1, exp_o.enr1);
      chk("cyc_RDA1", a.rda1, exp_o.rda1);
      chk("cyc_ALU_OP", a.alu_op, exp_o.alu_op);
      chk("cyc_G_LD", a.g_ld, exp_o.g_ld);
      chk("cyc_BUS_SEL", a.bus_sel, exp_o.bus_sel);
      chk("cyc_DONE", a.done, exp_o.done);
      chk("cyc_ILLEGAL", a.illegal, exp_o.illegal);
      chk("cyc_ICOUNT", a.icount, exp_o.icount);
    end
  end

  // Present one instruction, record the T1/T2/FIN snapshots and check accept-to-DONE latency.
  task automatic issue(input logic [9:0] ins, input int lat);
    int n;
    @(negedge CLKb);
    INSTR = ins;
    IVALID = 1'b1;
    n = 0;
    while (!IREADY && n < 10) begin
      @(negedge CLKb);
      n++;
    end
    chk("accept_ready", IREADY, 1);
    @(negedge CLKb);
    IVALID = 1'b0;
    INSTR = ~ins;
    t1 = sample();
    t2 = '0;
    n = 1;
    while (!DONE && n < 8) begin
      @(negedge CLKb);
      n++;
      if (n == 2) t2 = sample();
    end
    fin = sample();
    $display("instr %b latency %0d", ins, n);
    chk("latency", n, lat);
  endtask

  initial begin : watchdog
    #600000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    @(posedge CLKb);
    #1;
    chk("rst_IREADY", IREADY, 0);
    chk("rst_ENW", ENW, 0);
    chk("rst_BUS_SEL", BUS_SEL, 0);
    chk("rst_DONE", DONE, 0);
    chk("rst_ICOUNT", ICOUNT, 0);
    cmp_en = 1'b1;

    // LOAD R1 with IVALID already high across reset release.
    IVALID = 1'b1;
    INSTR = 10'b0000_01_00_00;
    @(negedge CLKb);
    @(negedge CLKb);
    RSTb = 1'b1;
    #1;
    chk("release_IREADY", IREADY, 0);
    issue(10'b0000_01_00_00, 2);
    chk("load_t1_BUS_SEL", t1.bus_sel, 2'b01);
    chk("load_t1_ENW", t1.enw, 1);
    chk("load_t1_WRA", t1.wra, 2'b01);
    chk("load_fin_DONE", fin.done, 1);

    // ADD R2,R3
    issue(10'b0010_10_11_00, 3);
    chk("add_t1_ENR0", t1.enr0, 1);
    chk("add_t1_RDA0", t1.rda0, 2'b10);
    chk("add_t1_ENR1", t1.enr1, 1);
    chk("add_t1_RDA1", t1.rda1, 2'b11);
    chk("add_t1_G_LD", t1.g_ld, 1);
    chk("add_t1_ALU_OP", t1.alu_op, 3'b000);
    chk("add_t1_ENW", t1.enw, 0);
    chk("add_t2_BUS_SEL", t2.bus_sel, 2'b11);
    chk("add_t2_ENW", t2.enw, 1);
    chk("add_t2_WRA", t2.wra, 2'b10);

    issue(10'b0000_11_00_00, 2);
    issue(10'b0001_10_10_00, 2);
    chk("movsame_t1_ENW", t1.enw, 1);
    chk("movsame_t1_WRA", t1.wra, 2'b10);
    chk("movsame_t1_RDA0", t1.rda0, 2'b10);
    issue(10'b0011_01_00_00, 3);
    chk("sub_t1_ALU_OP", t1.alu_op, 3'b001);
    issue(10'b0100_00_11_00, 3);
    issue(10'b0101_11_01_00, 3);
    chk("or_t2_ALU_OP", t2.alu_op, 3'b011);
    issue(10'b0110_01_10_00, 3);
    issue(10'b0111_10_01_00, 2);
    chk("ill7_fin_ILLEGAL", fin.illegal, 1);
    issue(10'b1111_00_00_00, 2);
    chk("ill15_t1_ENW", t1.enw, 0);
    chk("ill15_t1_ENR0", t1.enr0, 0);
    chk("ill15_t1_G_LD", t1.g_ld, 0);
    chk("ill15_fin_DONE", fin.done, 1);
    chk("ill15_fin_ILLEGAL", fin.illegal, 1);

    // Back-to-back MOV then XOR with IVALID held high.
    @(negedge CLKb);
    INSTR = 10'b0001_00_01_00;
    IVALID = 1'b1;
    n = 0;
    while (!IREADY && n < 10) begin
      @(negedge CLKb);
      n++;
    end
    chk("b2b_accept_ready", IREADY, 1);
    @(negedge CLKb);
    INSTR = 10'b1111_11_11_11;
    chk("b2b_mov_ENW", ENW, 1);
    chk("b2b_mov_RDA0", RDA0, 2'b01);
    chk("b2b_mov_WRA", WRA, 2'b00);
    chk("b2b_mov_BUS_SEL", BUS_SEL, 2'b10);
    @(negedge CLKb);
    INSTR = 10'b0110_11_11_00;
    chk("b2b_mov_DONE", DONE, 1);
    chk("b2b_fin_IREADY", IREADY, 0);
    @(negedge CLKb);
    chk("b2b_idle_IREADY", IREADY, 1);
    chk("b2b_idle_DONE", DONE, 0);
    @(negedge CLKb);
    IVALID = 1'b0;
    chk("b2b_xor_ALU_OP", ALU_OP, 3'b100);
    chk("b2b_xor_RDA0", RDA0, 2'b11);
    chk("b2b_xor_RDA1", RDA1, 2'b11);
    chk("b2b_xor_G_LD", G_LD, 1);
    @(negedge CLKb);
    chk("b2b_xor_t2_WRA", WRA, 2'b11);
    chk("b2b_xor_t2_ALU_OP", ALU_OP, 3'b100);
    @(negedge CLKb);
    chk("b2b_xor_DONE", DONE, 1);
    $display("back-to-back MOV/XOR sequence complete");

    // Reset pulse during T2 of SUB R1,R2.
    @(negedge CLKb);
    INSTR = 10'b0011_01_10_00;
    IVALID = 1'b1;
    n = 0;
    while (!IREADY && n < 10) begin
      @(negedge CLKb);
      n++;
    end
    chk("abort_accept_ready", IREADY, 1);
    @(negedge CLKb);
    IVALID = 1'b0;
    chk("abort_t1_ENR1", ENR1, 1);
    @(posedge CLKb);
    #2;
    chk("abort_t2_ENW", ENW, 1);
    RSTb = 1'b0;
    #1;
    chk("abort_ENW", ENW, 0);
    chk("abort_BUS_SEL", BUS_SEL, 0);
    chk("abort_IREADY", IREADY, 0);
    chk("abort_DONE", DONE, 0);
    @(negedge CLKb);
    #1;
    RSTb = 1'b1;
    repeat (4) @(negedge CLKb);
    chk("abort_idle_IREADY", IREADY, 1);
    chk("abort_ICOUNT", ICOUNT, 0);
    $display("reset abort during SUB complete");

    // 1024 LOADs: the counter wraps back to zero.
    for (int i = 0; i < 1024; i++) begin
      issue({4'b0000, 2'(i), 4'b0000}, 2);
      if (i == 511) begin
        @(negedge CLKb);
        chk("half_ICOUNT", ICOUNT, HALF_CNT);
      end
    end
    @(negedge CLKb);
    chk("wrap_ICOUNT", ICOUNT, 0);

    repeat (2) @(negedge CLKb);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
